// File: rtl/tt_sumador_serie.sv
// Serial W-bit add/sub/accumulate unit for a Tiny Tapeout tile: operands are loaded by nibble,
// computed through one 4-bit slice over W/4 cycles, and the result is read back by byte.
module tt_sumador_serie #(
   parameter int W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int NIB = W / 4;
   localparam int NBY = W / 8;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int PW  = (NBY > 1) ? $clog2(NBY) : 1;

   localparam logic [1:0] CMD_LOAD_A = 2'b00;
   localparam logic [1:0] CMD_LOAD_B = 2'b01;
   localparam logic [1:0] CMD_START  = 2'b10;
   localparam logic [1:0] CMD_READ   = 2'b11;

   localparam logic [1:0] MODE_SUB   = 2'b01;
   localparam logic [1:0] MODE_ACC   = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t          state_q;
   logic [W-1:0]    a_q, b_q, r_q;
   logic            strb_q;
   logic [IW-1:0]   idx_q;
   logic            carry_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [1:0]      mode_q;
   logic            cout_q, ovf_q, zero_q;

   logic [3:0]      a_nib [NIB];
   logic [3:0]      b_nib [NIB];
   logic [3:0]      r_nib [NIB];
   logic [7:0]      r_byte [NBY];

   genvar gi;
   generate
      for (gi = 0; gi < NIB; gi++) begin : g_nib
         assign a_nib[gi] = a_q[4*gi +: 4];
         assign b_nib[gi] = b_q[4*gi +: 4];
         assign r_nib[gi] = r_q[4*gi +: 4];
      end
      for (gi = 0; gi < NBY; gi++) begin : g_byte
         assign r_byte[gi] = r_q[8*gi +: 8];
      end
   endgenerate

   logic         event_w;
   logic [3:0]   x_nib, y_nib, s_nib;
   logic         c_out, c_msb;
   logic [W-1:0] r_upd;

   assign event_w = ui_in[7] & ~strb_q & ena;

   // One slice of the ripple; c_msb recovers the carry into the top bit for signed overflow.
   always_comb begin
      x_nib = (mode_q == MODE_ACC) ? r_nib[idx_q] : a_nib[idx_q];
      y_nib = (mode_q == MODE_SUB) ? ~b_nib[idx_q] : b_nib[idx_q];
      {c_out, s_nib} = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, carry_q};
      c_msb = x_nib[3] ^ y_nib[3] ^ s_nib[3];
      r_upd = r_q;
      r_upd[4*idx_q +: 4] = s_nib;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         strb_q   <= 1'b0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         rd_ptr_q <= '0;
         mode_q   <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         strb_q <= ui_in[7];
         case (state_q)
            IDLE: begin
               if (event_w) begin
                  case (uio_in[1:0])
                     CMD_LOAD_A: a_q <= {a_q[W-5:0], ui_in[3:0]};
                     CMD_LOAD_B: b_q <= {b_q[W-5:0], ui_in[3:0]};
                     CMD_READ:   rd_ptr_q <= (rd_ptr_q == PW'(NBY - 1)) ? '0 : rd_ptr_q + 1'b1;
                     CMD_START: begin
                        rd_ptr_q <= '0;
                        if (uio_in[3:2] == MODE_CLEAR) begin
                           r_q    <= '0;
                           cout_q <= 1'b0;
                           ovf_q  <= 1'b0;
                           zero_q <= 1'b0;
                        end else begin
                           mode_q  <= uio_in[3:2];
                           idx_q   <= '0;
                           carry_q <= (uio_in[3:2] == MODE_SUB);
                           state_q <= CALC;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            CALC: begin
               r_q     <= r_upd;
               carry_q <= c_out;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == IW'(NIB - 1)) begin
                  cout_q  <= c_out;
                  ovf_q   <= c_msb ^ c_out;
                  zero_q  <= (r_upd == '0);
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign uo_out  = r_byte[rd_ptr_q];
   assign uio_out = {(state_q == CALC), cout_q, ovf_q, zero_q, 4'b0000};
   assign uio_oe  = 8'hF0;

   logic unused_ok;
   assign unused_ok = &{1'b0, ui_in[6:4], uio_in[7:4]};

endmodule

// File: tb/tb_tt_sumador_serie.sv
// Bench for tt_sumador_serie: directed scenarios pinned to literal values, then random traffic
// checked every cycle against an arithmetic model of the tile.
module tb_tt_sumador_serie;
   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       ena    = 1'b1;
   logic [7:0] ui_in  = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   tt_sumador_serie #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: whole-word arithmetic, result appears NIB edges after START.
   logic [15:0] m_a = '0, m_b = '0, m_r = '0;
   logic        m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0, m_strb = 1'b0;
   logic [18:0] pend = '0;
   int          m_busy = 0;
   int          m_rd = 0;

   function automatic logic [18:0] op_model(input logic [1:0] mode, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] r);
      logic [16:0] full;
      logic [15:0] x;
      logic        ov;
      x = (mode == 2'b10) ? r : a;
      if (mode == 2'b01) begin
         full = {1'b0, a} + {1'b0, ~b} + 17'd1;
         ov   = (a[15] != b[15]) && (full[15] != a[15]);
      end else begin
         full = {1'b0, x} + {1'b0, b};
         ov   = (x[15] == b[15]) && (full[15] != x[15]);
      end
      return {full[16], ov, (full[15:0] == 16'h0000), full[15:0]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_a <= '0; m_b <= '0; m_r <= '0;
         m_cout <= 1'b0; m_ovf <= 1'b0; m_zero <= 1'b0;
         m_strb <= 1'b0; m_busy <= 0; m_rd <= 0;
      end else begin
         m_strb <= ui_in[7];
         if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) {m_cout, m_ovf, m_zero, m_r} <= pend;
         end else if (ui_in[7] && !m_strb && ena) begin
            case (uio_in[1:0])
               2'b00: m_a <= {m_a[11:0], ui_in[3:0]};
               2'b01: m_b <= {m_b[11:0], ui_in[3:0]};
               2'b11: m_rd <= (m_rd + 1) % 2;
               default: begin
                  m_rd <= 0;
                  if (uio_in[3:2] == 2'b11) begin
                     m_r <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_zero <= 1'b0;
                  end else begin
                     pend   <= op_model(uio_in[3:2], m_a, m_b, m_r);
                     m_busy <= NIB;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         logic [15:0] sh;
         @(negedge clk);
         sh = m_r >> (8 * m_rd);
         check("oe", uio_oe, 8'hF0);
         check("busy", uio_out[7], (m_busy > 0));
         if (m_busy == 0) begin
            check("byte", uo_out, sh[7:0]);
            check("flags", uio_out[6:0], {m_cout, m_ovf, m_zero, 4'b0000});
         end
      end
   end

   task automatic send(input logic [1:0] cmd, input logic [1:0] mode, input logic [3:0] nib);
      @(negedge clk);
      ui_in  = {1'b1, 3'b000, nib};
      uio_in = {4'b0000, mode, cmd};
      @(negedge clk);
      ui_in[7] = 1'b0;
   endtask

   task automatic load(input logic [1:0] cmd, input logic [15:0] v);
      for (int i = 3; i >= 0; i--) send(cmd, 2'b00, v[4*i +: 4]);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (uio_out[7] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (uio_out[7]) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_op(input logic [1:0] mode, output int cyc);
      send(2'b10, mode, 4'h0);
      wait_idle(cyc);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check("t1_rst_uo", uo_out, 8'h00);
      check("t1_rst_uio", uio_out, 8'h00);
      check("t1_rst_oe", uio_oe, 8'hF0);
      rst_n = 1'b1;
      @(negedge clk);
      check("t1_post_uo", uo_out, 8'h00);
      check("t1_post_uio", uio_out, 8'h00);

      load(2'b00, 16'h1234);
      load(2'b01, 16'h0FFF);
      do_op(2'b00, cyc);
      check("t2_busy_cycles", cyc, 4);
      check("t2_model_r", m_r, 16'h2233);
      check("t2_byte0", uo_out, 8'h33);
      check("t2_flags", uio_out, 8'h00);
      send(2'b11, 2'b00, 4'h0);
      check("t2_byte1", uo_out, 8'h22);
      send(2'b11, 2'b00, 4'h0);
      check("t2_wrap", uo_out, 8'h33);

      load(2'b00, 16'h0005);
      load(2'b01, 16'h0007);
      do_op(2'b01, cyc);
      check("t3a_byte0", uo_out, 8'hFE);
      check("t3a_flags", uio_out, 8'h00);
      send(2'b11, 2'b00, 4'h0);
      check("t3a_byte1", uo_out, 8'hFF);

      load(2'b00, 16'h1234);
      load(2'b01, 16'h1234);
      do_op(2'b01, cyc);
      check("t3b_byte0", uo_out, 8'h00);
      check("t3b_flags", uio_out, 8'h50);

      load(2'b00, 16'h7FFF);
      load(2'b01, 16'h0001);
      do_op(2'b00, cyc);
      check("t4a_flags", uio_out, 8'h20);
      send(2'b11, 2'b00, 4'h0);
      check("t4a_byte1", uo_out, 8'h80);

      load(2'b00, 16'hFFFF);
      do_op(2'b00, cyc);
      check("t4b_byte0", uo_out, 8'h00);
      check("t4b_flags", uio_out, 8'h50);

      send(2'b10, 2'b11, 4'h0);
      check("t5_clear_uo", uo_out, 8'h00);
      check("t5_clear_uio", uio_out, 8'h00);
      load(2'b01, 16'h0100);
      send(2'b10, 2'b10, 4'h0);
      @(negedge clk);
      ui_in  = {1'b1, 3'b000, 4'hF};
      uio_in = 8'h00;
      @(negedge clk);
      ui_in[7] = 1'b0;
      wait_idle(cyc);
      do_op(2'b10, cyc);
      do_op(2'b10, cyc);
      check("t5_model_r", m_r, 16'h0300);
      send(2'b11, 2'b00, 4'h0);
      check("t5_byte1", uo_out, 8'h03);
      check("t5_model_a", m_a, 16'hFFFF);
      do_op(2'b00, cyc);
      check("t5_add_byte0", uo_out, 8'hFF);
      check("t5_add_flags", uio_out, 8'h40);

      @(negedge clk);
      ui_in  = 8'h80;
      uio_in = 8'h02;
      @(negedge clk);
      ui_in[7] = 1'b0;
      @(negedge clk);
      check("t6_busy_mid", uio_out[7], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_busy", uio_out[7], 1'b0);
      check("t6_rst_uo", uo_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      load(2'b00, 16'h0021);
      load(2'b01, 16'h0012);
      do_op(2'b00, cyc);
      check("t6_fresh_byte0", uo_out, 8'h33);
      check("t6_fresh_flags", uio_out, 8'h00);

      repeat (300) begin
         int hold, gap;
         hold = $urandom_range(1, 3);
         gap  = $urandom_range(0, 2);
         @(negedge clk);
         ena    = ($urandom_range(0, 9) != 0);
         ui_in  = {1'b1, 3'($urandom), 4'($urandom)};
         uio_in = 8'($urandom);
         repeat (hold) @(negedge clk);
         ui_in[7] = 1'b0;
         repeat (gap) @(negedge clk);
      end
      ena = 1'b1;
      repeat (8) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/tt_sumador_serie.md
# tt_sumador_serie

Parametrised, multi-cycle successor to the 4-bit pin adder, built for the same Tiny Tapeout tile interface.

- Two W-bit operands are loaded a nibble at a time from the switches.
- The core adds, subtracts or accumulates them through a single 4-bit adder slice with a registered carry, taking W/4 cycles.
- The W-bit result is read back a byte at a time on the 7-segment outputs, with status flags on the bidirectional pins.

## Interface

- W, default 16, operand/result width; legal values 8, 16, 24, 32. NIB = W/4, NBY = W/8.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable; when low, new strobe events are ignored.
- ui_in  in  8  [3:0] data nibble, [6:4] unused, [7] strobe.
- uio_in  in  8  [1:0] command (00 LOAD_A, 01 LOAD_B, 10 START, 11 READ_NEXT), [3:2] mode (00 ADD, 01 SUB, 10 ACC, 11 CLEAR), [7:4] unused.
- uo_out  out  8  result byte R[8*rd_ptr+7 : 8*rd_ptr].
- uio_out  out  8  [7] busy, [6] cout, [5] ovf, [4] zero, [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

## Operation

Registers:
- A, B, R (each W bits), strb_q, state (IDLE/CALC), idx (log2 NIB bits), carry, rd_ptr (log2 NBY bits), mode_q, flags cout/ovf/zero.

Strobe events:
- An event occurs on an edge where ui_in[7]=1, strb_q=0 and ena=1.
- strb_q samples ui_in[7] on every edge, regardless of ena or state.
- A strobe held high produces exactly one event.
- Events that occur in CALC are dropped, not queued.

Commands, applied on an event in IDLE:
- LOAD_A: A <= {A[W-5:0], ui_in[3:0]}. Operands are entered MSB nibble first, NIB loads in total.
- LOAD_B: same as LOAD_A, applied to B.
- READ_NEXT: rd_ptr <= (rd_ptr+1) mod NBY.
- START with mode CLEAR: R, cout, ovf, zero and rd_ptr <= 0 in that same edge; state stays IDLE.
- START with any other mode:
  - mode_q <= mode, idx <= 0, rd_ptr <= 0.
  - carry <= 1 for SUB, otherwise 0.
  - state <= CALC.

CALC, one nibble per edge, LSB nibble first:
- X = A for ADD/SUB, and X = R (the value before the operation) for ACC.
- Y = ~B for SUB, otherwise B.
- Each edge computes {c, s} = X[4idx+3:4idx] + Y[4idx+3:4idx] + carry, writes R nibble idx <= s, carry <= c, idx <= idx+1.
- On the edge with idx = NIB-1, additionally:
  - cout <= c.
  - ovf <= carry into bit W-1 XOR c (signed overflow).
  - zero <= (final W-bit R == 0).
  - state <= IDLE.
- SUB computes A + ~B + 1, so cout=1 means no borrow (A >= B unsigned).
- ACC accumulates R += B.

Invariants:
- busy = (state == CALC).
- Loading A or B never changes R or the flags.
- ena going low during CALC does not stall it; the operation completes.

## Timing

- START event accepted at edge E: busy is high after E through edge E+NIB, and low after E+NIB.
- R and all flags are final after edge E+NIB, giving a latency of NIB cycles (4 for W=16).
- uo_out and uio_out are combinational from registers; there is no extra output stage.
- Reset: A, B, R, carry, idx, rd_ptr, strb_q and all flags go to 0, and state goes to IDLE, immediately on rst_n low.
  - So uo_out = 0, uio_out = 0 and uio_oe = F0.
  - Reset during CALC aborts the operation with no partial result retained.
- On an edge during CALC, an event is ignored even though strb_q updates. The strobe must therefore be released and re-asserted after busy falls to issue a new command.
- Back-to-back START: a new event may be accepted on the first edge after busy falls.

## Test plan

1. Reset, W=16: during and after reset uo_out=00, uio_out=00, uio_oe=F0.
2. LOAD_A 1,2,3,4, LOAD_B 0,F,F,F, START ADD:
   - busy is high exactly 4 cycles.
   - R=0x2233, uo_out=33, READ_NEXT gives 22, a second READ_NEXT wraps to 33.
   - cout=0, ovf=0, zero=0.
3. SUB cases:
   - 0x0005-0x0007 gives R=0xFFFE with cout=0, ovf=0.
   - 0x1234-0x1234 gives R=0 with zero=1, cout=1.
4. ADD cases:
   - 0x7FFF+0x0001 gives R=0x8000 with ovf=1, cout=0.
   - 0xFFFF+0x0001 gives R=0 with cout=1, zero=1, ovf=0.
5. CLEAR, B=0x0100, three ACC STARTs gives R=0x0300. A strobe toggled during busy and a LOAD_A in CALC are both ignored, so A is unchanged.
6. rst_n low in the 2nd CALC cycle of an ADD: busy drops at once, R=0, and a fresh ADD after reset produces the correct result.
